// File: rtl/queue_pkg.sv
// Shared types and helpers for the customer queue dispatch path.
// Holds FSM encodings, field widths and the rotating pick function.
package queue_pkg;

  localparam int NUM_W = 4;
  localparam int TIM_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    LD   = 3'd3,
    GAP  = 3'd4
  } state_t;

  // First idle slot at or after ptr, wrapping at n; returns {found, sel}.
  function automatic logic [2:0] rr_pick(
    input logic [3:0] busy,
    input logic [1:0] ptr,
    input logic [2:0] n
  );
    logic [2:0] k;
    logic       hit;
    logic [1:0] sel;
    hit = 1'b0;
    sel = ptr;
    for (int i = 0; i < 4; i++) begin
      k = {1'b0, ptr} + 3'(i);
      if (k >= n) k = k - n;
      if (3'(i) < n && !hit && !busy[k[1:0]]) begin
        hit = 1'b1;
        sel = k[1:0];
      end
    end
    return {hit, sel};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker over up to four requesters.
// A set busy bit means the slot cannot be chosen.
module rr_arbiter
  import queue_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] busy,
  input  logic [1:0]   ptr,
  output logic [1:0]   sel,
  output logic         found
);

  logic [3:0] b4;

  // Unused upper slots look permanently busy.
  always_comb begin
    b4 = '1;
    b4[N-1:0] = busy;
  end

  assign {found, sel} = rr_pick(b4, ptr, 3'(N));

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher from the customer FIFO to the service counters.
// One grant per five cycles; invalid entries are counted and discarded.
module rr_dispatcher
  import queue_pkg::*;
#(
  parameter int N_CNT = 3,
  parameter int SAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_emp,
  input  logic [NUM_W-1:0] fifo_num,
  input  logic [TIM_W-1:0] fifo_tim,
  output logic             fifo_re,
  input  logic [N_CNT-1:0] busy,
  output logic [N_CNT-1:0] ld,
  output logic [NUM_W-1:0] dn,
  output logic [TIM_W-1:0] dt,
  output logic [1:0]       rr_ptr,
  output logic [SAT_W-1:0] served,
  output logic [3:0]       dropped,
  output logic [2:0]       state_dbg
);

  state_t     state;
  state_t     nxt;
  logic [1:0] sel;
  logic [1:0] pick;
  logic       found;
  logic       go;
  logic       bad;

  rr_arbiter #(.N(N_CNT)) u_arb (
    .busy  (busy),
    .ptr   (rr_ptr),
    .sel   (pick),
    .found (found)
  );

  assign go  = en && !fifo_emp && found;
  assign bad = (fifo_num == '0) || (fifo_tim == '0);
  assign state_dbg = state;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (go) nxt = RD;
      RD:      nxt = CAP;
      CAP:     nxt = bad ? GAP : LD;
      LD:      nxt = GAP;
      GAP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= '0;
      rr_ptr  <= '0;
      fifo_re <= 1'b0;
      ld      <= '0;
      dn      <= '0;
      dt      <= '0;
      served  <= '0;
      dropped <= '0;
    end else begin
      fifo_re <= (state == IDLE) && go;
      ld      <= '0;
      if (state == IDLE && go) sel <= pick;
      if (state == CAP) begin
        dn <= fifo_num;
        dt <= fifo_tim;
        if (bad) begin
          if (dropped != 4'hf) dropped <= dropped + 4'd1;
        end else begin
          ld <= N_CNT'(1) << sel;
        end
      end
      // Pointer moves only once the strobe has actually gone out.
      if (state == LD) begin
        if (served != '1) served <= served + SAT_W'(1);
        rr_ptr <= (int'(sel) == N_CNT - 1) ? 2'd0 : sel + 2'd1;
      end
    end
  end

endmodule
